// File: rtl/render_queue_executor.sv
// ---------------------------------------------------------------------------
// render_queue_executor
//
// Walks an MCU-filled command queue starting at word 0 and rasterises
// FILL_RECT and CLEAR commands into VRAM pixel writes for the bank latched on
// the accepted start pulse. A one-cycle finished pulse marks the end of the
// queue; the error flag is sticky until the next accepted start.
//
// Ports
//   i_master_clk       only clock
//   i_reset            synchronous, active-high reset
//   i_render_start     one-cycle start pulse (ignored outside IDLE)
//   i_render_bank      target bank, sampled on an accepted start
//   o_render_finished  one-cycle done pulse
//   o_render_error     sticky error flag (unknown opcode / queue overrun)
//   o_queue_rd         queue read strobe
//   o_queue_addr       queue word address
//   i_queue_data       queue read data, valid one cycle after o_queue_rd
//   o_pix_valid        pixel write request
//   i_pix_ready        VRAM accepts when o_pix_valid && i_pix_ready
//   o_pix_addr         {bank, y[9:0], x[9:0]}
//   o_pix_data         RGB565 colour
// ---------------------------------------------------------------------------
module render_queue_executor #(
  parameter int QADDR_WIDTH = 8,
  parameter int H_RES       = 640,
  parameter int V_RES       = 480
) (
  input  logic                   i_master_clk,
  input  logic                   i_reset,
  input  logic                   i_render_start,
  input  logic                   i_render_bank,
  output logic                   o_render_finished,
  output logic                   o_render_error,
  output logic                   o_queue_rd,
  output logic [QADDR_WIDTH-1:0] o_queue_addr,
  input  logic [31:0]            i_queue_data,
  output logic                   o_pix_valid,
  input  logic                   i_pix_ready,
  output logic [20:0]            o_pix_addr,
  output logic [15:0]            o_pix_data
);

  typedef enum logic [3:0] {
    IDLE, RD_HDR, WT_HDR, RD_ARG1, WT_ARG1, RD_ARG2, WT_ARG2, DRAW, DONE
  } state_t;

  localparam logic [3:0]  OP_END   = 4'h0;
  localparam logic [3:0]  OP_FILL  = 4'h1;
  localparam logic [3:0]  OP_CLEAR = 4'h2;
  localparam logic [10:0] H_LIM    = 11'(H_RES);
  localparam logic [10:0] V_LIM    = 11'(V_RES);
  localparam logic [QADDR_WIDTH-1:0] PTR_MAX = {QADDR_WIDTH{1'b1}};

  state_t                 state;
  logic [QADDR_WIDTH-1:0] ptr;
  logic                   ptr_wrapped;
  logic                   bank;
  logic [9:0]             x_start;
  logic [9:0]             cur_x;
  logic [9:0]             cur_y;
  logic [10:0]            x_end;
  logic [10:0]            y_end;

  logic [3:0]  opcode;
  logic [9:0]  arg_lo;
  logic [9:0]  arg_hi;
  logic [10:0] x_sum;
  logic [10:0] y_sum;
  logic [10:0] clip_x_end;
  logic [10:0] clip_y_end;
  logic        rect_empty;
  logic        last_x;
  logic        last_y;
  logic        unused_bits;

  assign opcode = i_queue_data[31:28];
  assign arg_lo = i_queue_data[9:0];
  assign arg_hi = i_queue_data[25:16];

  // ARG2 arrives while x0/y0 already sit in x_start/cur_y, so the clipped
  // end coordinates are formed straight from the read data, 11 bits wide so
  // that x0+w never wraps.
  assign x_sum      = {1'b0, x_start} + {1'b0, arg_lo};
  assign y_sum      = {1'b0, cur_y} + {1'b0, arg_hi};
  assign clip_x_end = (x_sum > H_LIM) ? H_LIM : x_sum;
  assign clip_y_end = (y_sum > V_LIM) ? V_LIM : y_sum;
  assign rect_empty = (arg_lo == 10'd0) || (arg_hi == 10'd0) ||
                      ({1'b0, x_start} >= H_LIM) || ({1'b0, cur_y} >= V_LIM);

  assign last_x = (({1'b0, cur_x} + 11'd1) == x_end);
  assign last_y = (({1'b0, cur_y} + 11'd1) == y_end);

  assign unused_bits = ^i_queue_data[27:26];

  assign o_queue_addr = ptr;
  assign o_pix_addr   = {bank, cur_y, cur_x};

  // Single sequential FSM. Every output is a register (or a direct view of
  // one), so outputs are set on the transition into the state that owns
  // them. ptr_wrapped records that the last queue word has been consumed;
  // any further read request then becomes an overrun error instead.
  always_ff @(posedge i_master_clk) begin
    if (i_reset) begin
      state             <= IDLE;
      ptr               <= '0;
      ptr_wrapped       <= 1'b0;
      bank              <= 1'b0;
      x_start           <= '0;
      cur_x             <= '0;
      cur_y             <= '0;
      x_end             <= '0;
      y_end             <= '0;
      o_render_finished <= 1'b0;
      o_render_error    <= 1'b0;
      o_queue_rd        <= 1'b0;
      o_pix_valid       <= 1'b0;
      o_pix_data        <= '0;
    end else begin
      o_queue_rd        <= 1'b0;
      o_render_finished <= 1'b0;
      case (state)
        IDLE: begin
          if (i_render_start) begin
            bank           <= i_render_bank;
            ptr            <= '0;
            ptr_wrapped    <= 1'b0;
            o_render_error <= 1'b0;
            o_queue_rd     <= 1'b1;
            state          <= RD_HDR;
          end
        end

        RD_HDR, RD_ARG1, RD_ARG2: begin
          ptr <= ptr + 1'b1;
          if (ptr == PTR_MAX) ptr_wrapped <= 1'b1;
          case (state)
            RD_HDR:  state <= WT_HDR;
            RD_ARG1: state <= WT_ARG1;
            default: state <= WT_ARG2;
          endcase
        end

        WT_HDR: begin
          o_pix_data <= i_queue_data[15:0];
          case (opcode)
            OP_FILL: begin
              if (ptr_wrapped) begin
                o_render_error    <= 1'b1;
                o_render_finished <= 1'b1;
                state             <= DONE;
              end else begin
                o_queue_rd <= 1'b1;
                state      <= RD_ARG1;
              end
            end
            OP_CLEAR: begin
              x_start     <= '0;
              cur_x       <= '0;
              cur_y       <= '0;
              x_end       <= H_LIM;
              y_end       <= V_LIM;
              o_pix_valid <= 1'b1;
              state       <= DRAW;
            end
            OP_END: begin
              o_render_finished <= 1'b1;
              state             <= DONE;
            end
            default: begin
              o_render_error    <= 1'b1;
              o_render_finished <= 1'b1;
              state             <= DONE;
            end
          endcase
        end

        WT_ARG1: begin
          x_start <= arg_lo;
          cur_x   <= arg_lo;
          cur_y   <= arg_hi;
          if (ptr_wrapped) begin
            o_render_error    <= 1'b1;
            o_render_finished <= 1'b1;
            state             <= DONE;
          end else begin
            o_queue_rd <= 1'b1;
            state      <= RD_ARG2;
          end
        end

        WT_ARG2: begin
          x_end <= clip_x_end;
          y_end <= clip_y_end;
          if (!rect_empty) begin
            o_pix_valid <= 1'b1;
            state       <= DRAW;
          end else if (ptr_wrapped) begin
            o_render_error    <= 1'b1;
            o_render_finished <= 1'b1;
            state             <= DONE;
          end else begin
            o_queue_rd <= 1'b1;
            state      <= RD_HDR;
          end
        end

        // Counters move only on acceptance, which keeps address and data
        // frozen through a stall. The next header read is issued in the
        // cycle right after the last pixel is taken.
        DRAW: begin
          if (i_pix_ready) begin
            if (last_x) begin
              if (last_y) begin
                o_pix_valid <= 1'b0;
                if (ptr_wrapped) begin
                  o_render_error    <= 1'b1;
                  o_render_finished <= 1'b1;
                  state             <= DONE;
                end else begin
                  o_queue_rd <= 1'b1;
                  state      <= RD_HDR;
                end
              end else begin
                cur_x <= x_start;
                cur_y <= cur_y + 1'b1;
              end
            end else begin
              cur_x <= cur_x + 1'b1;
            end
          end
        end

        DONE: state <= IDLE;

        default: state <= IDLE;
      endcase
    end
  end

endmodule
